// File: rtl/sample_batch_source.sv
// Producer end of the sample-count path: forwards exactly BATCH samples through one
// registered valid/ready stage, strobing cnt_up per delivered sample and flagging the last one.
`timescale 1ns/1ps
module sample_batch_source #(
    parameter int DATA_W = 16,
    parameter int BATCH  = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              cnt_up_o,
    output logic              busy_o,
    output logic              batch_done_o
);

    localparam int CNT_W = $clog2(BATCH + 1);
    localparam logic [CNT_W-1:0] BATCH_C  = CNT_W'(BATCH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]    dlv_cnt_q, dlv_cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                batch_done_q, batch_done_d;
    logic                in_xfer, out_xfer;

    // Accept only while the batch is short of BATCH and the output stage frees up this cycle.
    assign in_ready_o = (state_q == STREAM) && (acc_cnt_q < BATCH_C) && (!out_valid_q || out_ready_i);
    assign in_xfer    = in_valid_i && in_ready_o;
    assign out_xfer   = out_valid_q && out_ready_i;

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign cnt_up_o     = out_xfer;
    assign busy_o       = (state_q != IDLE);
    assign batch_done_o = batch_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            acc_cnt_q    <= '0;
            dlv_cnt_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            dlv_cnt_q    <= dlv_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            batch_done_q <= batch_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        dlv_cnt_d    = dlv_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        batch_done_d = 1'b0;

        if (abort_i) begin
            state_d     = IDLE;
            acc_cnt_d   = '0;
            dlv_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = STREAM;
                        acc_cnt_d = '0;
                        dlv_cnt_d = '0;
                    end
                end
                STREAM: begin
                    if (out_xfer) begin
                        dlv_cnt_d = dlv_cnt_q + CNT_W'(1);
                        if (!in_xfer) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end
                    end
                    if (in_xfer) begin
                        out_data_d  = in_data_i;
                        out_valid_d = 1'b1;
                        out_last_d  = (acc_cnt_q == LAST_IDX);
                        acc_cnt_d   = acc_cnt_q + CNT_W'(1);
                    end
                    // No input can be accepted alongside the final delivery, so the stage empties here.
                    if (out_xfer && out_last_q) begin
                        state_d      = DONE;
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        batch_done_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_batch_source.sv
// Scoreboard bench for sample_batch_source: randomized source/sink, expected batch pushed at start,
// monitor pops on every delivered sample; small BATCH=4/1 instances check last/done placement.
`timescale 1ns/1ps
module tb_sample_batch_source;

    localparam int DATA_W = 16;
    localparam int BATCH  = 1000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } expT;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic              outLast;
    logic              cntUp;
    logic              busy;
    logic              batchDone;

    logic              smallStart;
    logic              sInReady   [2];
    logic [DATA_W-1:0] sOutData   [2];
    logic              sOutValid  [2];
    logic              sOutLast   [2];
    logic              sCntUp     [2];
    logic              sBusy      [2];
    logic              sBatchDone [2];

    expT               expQ[$];
    int                compared   = 0;
    int                mismatched = 0;
    int                cycleNo    = 0;
    int                cntUpCount = 0;
    int                batchCount = 0;
    int                firstCntUp = 0;
    int                lastCntUp  = 0;
    int                flushReq   = 0;
    int                readyMode  = 0;
    int                validMode  = 0;
    int                srcCount   = 0;
    int                srcBase    = 0;
    logic [DATA_W-1:0] dataMask   = '0;
    int                smallIdx     [2];
    int                smallLastCnt [2];
    int                smallDoneCnt [2];
    int                smallBatch   [2];

    sample_batch_source #(.DATA_W(DATA_W), .BATCH(BATCH)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReady),
        .out_data_o(outData), .out_valid_o(outValid), .out_ready_i(outReady),
        .out_last_o(outLast), .cnt_up_o(cntUp), .busy_o(busy), .batch_done_o(batchDone)
    );

    sample_batch_source #(.DATA_W(DATA_W), .BATCH(4)) dutB4 (
        .clk_i(clk), .rst_i(rst), .start_i(smallStart), .abort_i(1'b0),
        .in_data_i(inData), .in_valid_i(1'b1), .in_ready_o(sInReady[0]),
        .out_data_o(sOutData[0]), .out_valid_o(sOutValid[0]), .out_ready_i(1'b1),
        .out_last_o(sOutLast[0]), .cnt_up_o(sCntUp[0]), .busy_o(sBusy[0]), .batch_done_o(sBatchDone[0])
    );

    sample_batch_source #(.DATA_W(DATA_W), .BATCH(1)) dutB1 (
        .clk_i(clk), .rst_i(rst), .start_i(smallStart), .abort_i(1'b0),
        .in_data_i(inData), .in_valid_i(1'b1), .in_ready_o(sInReady[1]),
        .out_data_o(sOutData[1]), .out_valid_o(sOutValid[1]), .out_ready_i(1'b1),
        .out_last_o(sOutLast[1]), .cnt_up_o(sCntUp[1]), .busy_o(sBusy[1]), .batch_done_o(sBatchDone[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycleNo++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cycleNo);
        end
    endtask

    // Source: holds a sample until accepted; sample k of the batch carries k ^ dataMask.
    initial begin
        logic fire;
        int   idx;
        inValid = 1'b0;
        inData  = '0;
        forever begin
            @(negedge clk);
            fire = inValid && inReady;
            @(posedge clk);
            #1;
            if (fire) srcCount++;
            inValid = (validMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            idx     = srcCount - srcBase;
            inData  = DATA_W'(idx) ^ dataMask;
        end
    end

    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       outReady = 1'b1;
                1:       outReady = ~outReady;
                2:       outReady = ($urandom_range(0, 2) != 0);
                default: outReady = 1'b0;
            endcase
        end
    end

    // Monitor for the main instance: pops the scoreboard on every delivered sample.
    initial begin
        logic              prevStall;
        logic [DATA_W-1:0] prevData;
        logic              prevLast;
        int                flushAck;
        int                doneStage;
        expT               e;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        flushAck  = 0;
        doneStage = 0;
        forever begin
            @(negedge clk);
            if (flushAck != flushReq) begin
                flushAck   = flushReq;
                expQ.delete();
                cntUpCount = 0;
                doneStage  = 0;
                prevStall  = 1'b0;
            end
            if (prevStall) begin
                checkOutput("stall_valid_held", int'(outValid), 1);
                checkOutput("stall_data_held", int'(outData), int'(prevData));
                checkOutput("stall_last_held", int'(outLast), int'(prevLast));
            end
            if (cntUp) begin
                if (cntUpCount == 0) firstCntUp = cycleNo;
                lastCntUp = cycleNo;
                cntUpCount++;
            end
            case (doneStage)
                1: begin
                    checkOutput("batch_done_pulse", int'(batchDone), 1);
                    checkOutput("busy_in_done", int'(busy), 1);
                    doneStage = 2;
                end
                2: begin
                    checkOutput("batch_done_one_cycle", int'(batchDone), 0);
                    checkOutput("busy_after_done", int'(busy), 0);
                    checkOutput("cnt_up_per_batch", cntUpCount, BATCH);
                    cntUpCount = 0;
                    batchCount++;
                    doneStage = 0;
                end
                default: checkOutput("spurious_batch_done", int'(batchDone), 0);
            endcase
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_sample", int'(outData), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", int'(outData), int'(e.data));
                    checkOutput("out_last", int'(outLast), int'(e.last));
                    if (e.last) doneStage = 1;
                end
            end
            prevStall = outValid && !outReady;
            prevData  = outData;
            prevLast  = outLast;
        end
    end

    initial begin
        smallBatch[0] = 4;
        smallBatch[1] = 1;
        for (int i = 0; i < 2; i++) begin
            smallIdx[i]     = 0;
            smallLastCnt[i] = 0;
            smallDoneCnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (sOutValid[i]) begin
                    smallIdx[i]++;
                    if (sOutLast[i]) begin
                        checkOutput($sformatf("small%0d_last_position", smallBatch[i]), smallIdx[i], smallBatch[i]);
                        smallLastCnt[i]++;
                    end
                end
                if (sBatchDone[i]) smallDoneCnt[i]++;
            end
        end
    end

    // Loads the expected batch into the scoreboard, then pulses start for one cycle.
    task automatic applyStimulus(input logic [DATA_W-1:0] mask, output int startCycle);
        expT e;
        @(posedge clk);
        #2;
        dataMask = mask;
        srcBase  = srcCount;
        for (int k = 0; k < BATCH; k++) begin
            e.data = DATA_W'(k) ^ mask;
            e.last = (k == BATCH - 1);
            expQ.push_back(e);
        end
        @(posedge clk);
        #2;
        start      = 1'b1;
        startCycle = cycleNo;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic waitBatch(input int budget);
        int target;
        int n;
        target = batchCount + 1;
        n      = 0;
        while (batchCount < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("batch_completed_in_time", int'(batchCount >= target), 1);
    endtask

    task automatic waitSamples(input int target, input int budget);
        int n;
        n = 0;
        while (cntUpCount < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("samples_reached_in_time", int'(cntUpCount >= target), 1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_out_data"}, int'(outData), 0);
        checkOutput({tag, "_out_valid"}, int'(outValid), 0);
        checkOutput({tag, "_out_last"}, int'(outLast), 0);
        checkOutput({tag, "_batch_done"}, int'(batchDone), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_in_ready"}, int'(inReady), 0);
        checkOutput({tag, "_cnt_up"}, int'(cntUp), 0);
    endtask

    initial begin
        int startCycle;
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        smallStart = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkIdleOutputs("reset");
        rst = 1'b0;

        $display("[TB] full-throughput batch");
        readyMode = 0;
        validMode = 0;
        applyStimulus(DATA_W'($urandom), startCycle);
        waitBatch(1200);
        checkOutput("first_cnt_up_cycle", firstCntUp, startCycle + 2);
        checkOutput("last_cnt_up_cycle", lastCntUp, startCycle + BATCH + 1);

        $display("[TB] toggling out_ready, incrementing data");
        readyMode = 1;
        applyStimulus('0, startCycle);
        waitBatch(3000);

        $display("[TB] random handshakes, start pulsed mid-batch");
        readyMode = 2;
        validMode = 1;
        applyStimulus(DATA_W'($urandom), startCycle);
        waitSamples(500, 3000);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitBatch(5000);

        $display("[TB] abort during stall");
        applyStimulus(DATA_W'($urandom), startCycle);
        waitSamples(300, 2000);
        readyMode = 3;
        n = 0;
        while (!(outValid && !outReady) && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("abort_stall_reached", int'(outValid && !outReady), 1);
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        checkOutput("abort_out_valid", int'(outValid), 0);
        checkOutput("abort_out_last", int'(outLast), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_in_ready", int'(inReady), 0);
        flushReq++;
        readyMode = 2;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("abort_stays_idle", int'(busy), 0);
        applyStimulus(DATA_W'($urandom), startCycle);
        waitBatch(5000);

        $display("[TB] reset mid-batch");
        readyMode = 0;
        validMode = 0;
        applyStimulus(DATA_W'($urandom), startCycle);
        waitSamples(700, 1000);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkIdleOutputs("midreset");
        rst = 1'b0;
        flushReq++;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("reset_needs_start_busy", int'(busy), 0);
        checkOutput("reset_needs_start_valid", int'(outValid), 0);
        applyStimulus(DATA_W'($urandom), startCycle);
        waitBatch(1200);

        $display("[TB] BATCH=4 and BATCH=1 instances");
        @(posedge clk);
        #2;
        smallStart = 1'b1;
        @(posedge clk);
        #2;
        smallStart = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("small%0d_samples", smallBatch[i]), smallIdx[i], smallBatch[i]);
            checkOutput($sformatf("small%0d_last_count", smallBatch[i]), smallLastCnt[i], 1);
            checkOutput($sformatf("small%0d_done_count", smallBatch[i]), smallDoneCnt[i], 1);
            checkOutput($sformatf("small%0d_idle_after", smallBatch[i]), int'(sBusy[i]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
